digclk_alarm_p: RTL and testbench

Parametrised successor to the team's HH:MM:SS digital clock. It keeps time from a prescaled system clock and supports button-driven time setting with edge detection. It adds a separately settable alarm with a bounded ring duration and a runtime 12/24-hour display mode. It sits between the board clock/button inputs and the seven-segment display driver.

---
 rtl/digclk_alarm_p.sv | 211 +++++++++++++++++++++
 tb/tb_digclk_alarm_p.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digclk_alarm_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : digclk_alarm_p
// Brief    : HH:MM:SS clock with button time/alarm setting, bounded alarm ring
//            and 12/24-hour display decode.
// Revision : 1.0 - initial release
// ============================================================================
module digclk_alarm_p #(
    parameter int TICKS_PER_SEC = 1,
    parameter int RING_SECS     = 10,
    parameter int PRE_W         = 26
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       en,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       inc_min,
    input  logic       inc_hrs,
    input  logic       mode12,
    input  logic       alarm_en,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hrs,
    output logic [4:0] disp_hrs,
    output logic       pm,
    output logic [5:0] alarm_min,
    output logic [4:0] alarm_hrs,
    output logic       alarm_ring
);

    localparam int                RING_W      = $clog2(RING_SECS + 1);
    localparam logic [PRE_W-1:0]  c_PRE_MAX   = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [RING_W-1:0] c_RING_LOAD = RING_W'(RING_SECS);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_clr_pre;
    logic              w_pre_run;
    logic              w_edit_time;
    logic              w_edit_alarm;

    logic [PRE_W-1:0]  r_pre;
    logic [5:0]        r_sec;
    logic [5:0]        r_min;
    logic [4:0]        r_hrs;
    logic [5:0]        r_amin;
    logic [4:0]        r_ahrs;
    logic [RING_W-1:0] r_ring_cnt;
    logic              r_ring;
    logic              r_min_q;
    logic              r_hrs_q;

    logic              w_min_edge;
    logic              w_hrs_edge;
    logic              w_tick;
    logic              w_sec_wrap;
    logic              w_min_wrap;
    logic [5:0]        w_sec_nx;
    logic [5:0]        w_min_nx;
    logic [4:0]        w_hrs_nx;
    logic [5:0]        w_min_inc;
    logic [4:0]        w_hrs_inc;
    logic [5:0]        w_amin_inc;
    logic [4:0]        w_ahrs_inc;
    logic              w_trigger;
    logic              w_ring_clr;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Mode selection depends only on the level inputs; set_time dominates.
    always_comb begin
        w_next       = ST_RUN;
        w_clr_pre    = 1'b0;
        w_pre_run    = 1'b0;
        w_edit_time  = 1'b0;
        w_edit_alarm = 1'b0;
        if (set_time) begin
            w_next = ST_SET_TIME;
        end else if (set_alarm) begin
            w_next = ST_SET_ALARM;
        end
        w_clr_pre    = (w_next == ST_SET_TIME) ||
                       ((r_state != ST_RUN) && (w_next == ST_RUN));
        w_pre_run    = en && (r_state != ST_SET_TIME) && !w_clr_pre;
        w_edit_time  = (r_state == ST_SET_TIME);
        w_edit_alarm = (r_state == ST_SET_ALARM);
    end

    assign w_min_edge = inc_min & ~r_min_q;
    assign w_hrs_edge = inc_hrs & ~r_hrs_q;
    assign w_tick     = w_pre_run && (r_pre == c_PRE_MAX);

    assign w_sec_wrap = (r_sec == 6'd59);
    assign w_min_wrap = (r_min == 6'd59);
    assign w_sec_nx   = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_min_nx   = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_min + 6'd1) : r_min;
    assign w_hrs_nx   = (w_sec_wrap && w_min_wrap) ?
                        ((r_hrs == 5'd23) ? 5'd0 : r_hrs + 5'd1) : r_hrs;

    assign w_min_inc  = (r_min  == 6'd59) ? 6'd0 : r_min  + 6'd1;
    assign w_hrs_inc  = (r_hrs  == 5'd23) ? 5'd0 : r_hrs  + 5'd1;
    assign w_amin_inc = (r_amin == 6'd59) ? 6'd0 : r_amin + 6'd1;
    assign w_ahrs_inc = (r_ahrs == 5'd23) ? 5'd0 : r_ahrs + 5'd1;

    // Only a running tick landing exactly on HH:MM:00 arms the ring.
    assign w_trigger  = w_tick && (r_state == ST_RUN) && alarm_en &&
                        (w_sec_nx == 6'd0) && (w_min_nx == r_amin) &&
                        (w_hrs_nx == r_ahrs);
    assign w_ring_clr = w_min_edge || w_hrs_edge || !alarm_en ||
                        (w_next == ST_SET_TIME);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pre   <= '0;
            r_min_q <= 1'b0;
            r_hrs_q <= 1'b0;
        end else begin
            r_min_q <= inc_min;
            r_hrs_q <= inc_hrs;
            if (w_clr_pre) begin
                r_pre <= '0;
            end else if (w_pre_run) begin
                r_pre <= (r_pre == c_PRE_MAX) ? '0 : r_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_hrs  <= 5'd0;
            r_amin <= 6'd0;
            r_ahrs <= 5'd0;
        end else begin
            if (w_next == ST_SET_TIME) begin
                r_sec <= 6'd0;
            end else if (w_tick) begin
                r_sec <= w_sec_nx;
            end

            if (w_edit_time) begin
                if (w_min_edge) r_min <= w_min_inc;
                if (w_hrs_edge) r_hrs <= w_hrs_inc;
            end else if (w_tick) begin
                r_min <= w_min_nx;
                r_hrs <= w_hrs_nx;
            end

            if (w_edit_alarm) begin
                if (w_min_edge) r_amin <= w_amin_inc;
                if (w_hrs_edge) r_ahrs <= w_ahrs_inc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (w_ring_clr) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (w_trigger) begin
            r_ring     <= 1'b1;
            r_ring_cnt <= c_RING_LOAD;
        end else if (w_tick && r_ring) begin
            if (r_ring_cnt <= RING_W'(1)) begin
                r_ring     <= 1'b0;
                r_ring_cnt <= '0;
            end else begin
                r_ring_cnt <= r_ring_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        disp_hrs = r_hrs;
        if (mode12) begin
            if (r_hrs == 5'd0) begin
                disp_hrs = 5'd12;
            end else if (r_hrs > 5'd12) begin
                disp_hrs = r_hrs - 5'd12;
            end
        end
    end

    assign pm         = (r_hrs >= 5'd12);
    assign sec        = r_sec;
    assign min        = r_min;
    assign hrs        = r_hrs;
    assign alarm_min  = r_amin;
    assign alarm_hrs  = r_ahrs;
    assign alarm_ring = r_ring;

endmodule
`default_nettype wire

// File: tb/tb_digclk_alarm_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_digclk_alarm_p
// Brief    : Directed self-checking bench for digclk_alarm_p.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digclk_alarm_p;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       set_time = 1'b0;
    logic       set_alarm = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hrs = 1'b0;
    logic       mode12 = 1'b0;
    logic       alarm_en = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hrs;
    logic [4:0] disp_hrs;
    logic       pm;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hrs;
    logic       alarm_ring;

    int n_cmp = 0;
    int n_err = 0;

    digclk_alarm_p #(
        .TICKS_PER_SEC(1),
        .RING_SECS    (5),
        .PRE_W        (4)
    ) u_dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .set_time  (set_time),
        .set_alarm (set_alarm),
        .inc_min   (inc_min),
        .inc_hrs   (inc_hrs),
        .mode12    (mode12),
        .alarm_en  (alarm_en),
        .sec       (sec),
        .min       (min),
        .hrs       (hrs),
        .disp_hrs  (disp_hrs),
        .pm        (pm),
        .alarm_min (alarm_min),
        .alarm_hrs (alarm_hrs),
        .alarm_ring(alarm_ring)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic press(input logic m, input logic h, input int gap);
        inc_min = m;
        inc_hrs = h;
        step(1);
        inc_min = 1'b0;
        inc_hrs = 1'b0;
        step(gap);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hrs"}, 32'(hrs), 32'(h));
        check({tag, ".min"}, 32'(min), 32'(m));
        check({tag, ".sec"}, 32'(sec), 32'(s));
    endtask

    // From SET_TIME entry, bump minutes n times, release and run to HH:01:58.
    task automatic preset_to_58(input int n);
        set_time = 1'b1;
        step(1);
        for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1);
        set_time = 1'b0;
        step(1);
        step(58);
    endtask

    initial begin
        // 1: reset, long run, freeze
        step(5);
        check_time("reset", 0, 0, 0);
        check("reset.alarm_min", 32'(alarm_min), 0);
        check("reset.alarm_hrs", 32'(alarm_hrs), 0);
        check("reset.ring", 32'(alarm_ring), 0);
        reset = 1'b0;
        en    = 1'b1;
        step(3661);
        check_time("run3661", 1, 1, 1);
        check("run3661.disp24", 32'(disp_hrs), 1);
        check("run3661.pm", 32'(pm), 0);
        en = 1'b0;
        step(50);
        check_time("frozen", 1, 1, 1);

        // 2: preload 23:59:59 and roll over with alarm disarmed at 00:00
        reset = 1'b1;
        step(1);
        reset    = 1'b0;
        en       = 1'b1;
        set_time = 1'b1;
        step(1);
        for (int i = 0; i < 23; i++) press(1'b0, 1'b1, 1);
        for (int i = 0; i < 59; i++) press(1'b1, 1'b0, 1);
        check_time("preload", 23, 59, 0);
        mode12 = 1'b1;
        step(1);
        check("h23.disp12", 32'(disp_hrs), 11);
        check("h23.pm", 32'(pm), 1);
        mode12   = 1'b0;
        set_time = 1'b0;
        step(1);
        step(59);
        check_time("pre_roll", 23, 59, 59);
        step(1);
        check_time("rollover", 0, 0, 0);
        check("rollover.ring", 32'(alarm_ring), 0);

        // 3: set-mode entry clears seconds, edits, freeze, resume
        step(17);
        check("t17.sec", 32'(sec), 17);
        set_time = 1'b1;
        step(1);
        check_time("set_entry", 0, 0, 0);
        press(1'b1, 1'b1, 19);
        check("both.min", 32'(min), 1);
        check("both.hrs", 32'(hrs), 1);
        press(1'b1, 1'b0, 19);
        press(1'b1, 1'b0, 19);
        press(1'b0, 1'b1, 19);
        check_time("set_done", 2, 3, 0);
        step(30);
        check_time("set_frozen", 2, 3, 0);
        set_time = 1'b0;
        step(1);
        step(5);
        check_time("resume", 2, 3, 5);

        // 4: 12/24-hour decode
        reset = 1'b1;
        step(1);
        reset    = 1'b0;
        en       = 1'b0;
        set_time = 1'b1;
        mode12   = 1'b1;
        step(1);
        check("h0.disp12", 32'(disp_hrs), 12);
        check("h0.pm", 32'(pm), 0);
        press(1'b0, 1'b1, 1);
        check("h1.disp12", 32'(disp_hrs), 1);
        check("h1.pm", 32'(pm), 0);
        for (int i = 0; i < 11; i++) press(1'b0, 1'b1, 1);
        check("h12.disp12", 32'(disp_hrs), 12);
        check("h12.pm", 32'(pm), 1);
        press(1'b0, 1'b1, 1);
        check("h13.hrs", 32'(hrs), 13);
        check("h13.disp12", 32'(disp_hrs), 1);
        check("h13.pm", 32'(pm), 1);
        mode12 = 1'b0;
        step(1);
        check("h13.disp24", 32'(disp_hrs), 13);
        set_time = 1'b0;

        // 5a: alarm at 00:02 rings for exactly five ticks
        reset = 1'b1;
        step(1);
        reset     = 1'b0;
        set_alarm = 1'b1;
        step(1);
        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 1);
        check("alarm.min", 32'(alarm_min), 2);
        check("alarm.hrs", 32'(alarm_hrs), 0);
        check_time("alarm_set_time", 0, 0, 0);
        set_alarm = 1'b0;
        set_time  = 1'b1;
        step(1);
        press(1'b1, 1'b0, 1);
        check("t0100.min", 32'(min), 1);
        alarm_en = 1'b1;
        set_time = 1'b0;
        en       = 1'b1;
        step(1);
        check_time("leave", 0, 1, 0);
        step(58);
        check_time("t0158", 0, 1, 58);
        check("t0158.ring", 32'(alarm_ring), 0);
        step(1);
        check("t0159.ring", 32'(alarm_ring), 0);
        step(1);
        check_time("t0200", 0, 2, 0);
        check("t0200.ring", 32'(alarm_ring), 1);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("ring_tick%0d", k), 32'(alarm_ring), 1);
        end
        step(1);
        check("ring_end", 32'(alarm_ring), 0);
        check("ring_end.sec", 32'(sec), 5);

        // 5b: button edge on the second ring tick cancels it
        preset_to_58(59);
        check_time("re_t0158", 0, 1, 58);
        step(2);
        check("re_t0200.ring", 32'(alarm_ring), 1);
        step(1);
        check("re_tick1.ring", 32'(alarm_ring), 1);
        inc_min = 1'b1;
        step(1);
        check("btn_clear.ring", 32'(alarm_ring), 0);
        check("btn_clear.min", 32'(min), 2);
        inc_min = 1'b0;
        step(3);
        check("btn_clear.hold", 32'(alarm_ring), 0);

        // 6: ring persists into SET_ALARM and through en=0, reset clears all
        preset_to_58(59);
        step(2);
        check("r6.ring", 32'(alarm_ring), 1);
        set_alarm = 1'b1;
        step(1);
        check("r6.set_alarm.ring", 32'(alarm_ring), 1);
        en = 1'b0;
        step(10);
        check("r6.en0.ring", 32'(alarm_ring), 1);
        reset = 1'b1;
        step(1);
        check_time("r6.reset", 0, 0, 0);
        check("r6.reset.alarm_min", 32'(alarm_min), 0);
        check("r6.reset.alarm_hrs", 32'(alarm_hrs), 0);
        check("r6.reset.ring", 32'(alarm_ring), 0);
        check("r6.reset.disp", 32'(disp_hrs), 0);
        check("r6.reset.pm", 32'(pm), 0);
        reset     = 1'b0;
        set_alarm = 1'b0;
        en        = 1'b1;
        step(1);
        check("r6.run_state.sec", 32'(sec), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
